// File: rtl/ip_ttl_update.sv
// Router pipeline stage: decrements IPv4 TTL with an incremental checksum patch and
// diverts TTL-expired packets to the ingress port's CPU queue, behind a small input FIFO.
module ip_ttl_update #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int SRC_PORT_POS         = 16,
    parameter int DST_PORT_POS         = 24,
    parameter int FIFO_DEPTH_BITS      = 4
) (
    input  logic                                AXI_ACLK,
    input  logic                                AXI_RESET,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      S_AXIS_TDATA,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    S_AXIS_TSTRB,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     S_AXIS_TUSER,
    input  logic                                S_AXIS_TVALID,
    output logic                                S_AXIS_TREADY,
    input  logic                                S_AXIS_TLAST,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]      M_AXIS_TDATA,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    M_AXIS_TSTRB,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]     M_AXIS_TUSER,
    output logic                                M_AXIS_TVALID,
    input  logic                                M_AXIS_TREADY,
    output logic                                M_AXIS_TLAST,
    input  logic                                counter_reset,
    output logic [31:0]                         ipv4_count,
    output logic [31:0]                         ttl_expired_count,
    output logic [31:0]                         non_ip_count
);

    localparam int DEPTH  = 2 ** FIFO_DEPTH_BITS;
    localparam int STRB_W = C_S_AXIS_DATA_WIDTH / 8;
    localparam int FIFO_W = C_S_AXIS_DATA_WIDTH + STRB_W + C_S_AXIS_TUSER_WIDTH + 1;
    localparam logic [FIFO_DEPTH_BITS:0]   NEARLY_FULL_LEVEL = (FIFO_DEPTH_BITS+1)'(DEPTH - 1);
    localparam logic [FIFO_DEPTH_BITS:0]   COUNT_ONE         = (FIFO_DEPTH_BITS+1)'(1);
    localparam logic [FIFO_DEPTH_BITS-1:0] PTR_ONE           = FIFO_DEPTH_BITS'(1);

    typedef enum logic {HEADER, BODY} state_t;

    state_t state, next_state;

    logic [FIFO_W-1:0]              fifo_mem [DEPTH];
    logic [FIFO_DEPTH_BITS-1:0]     wr_ptr, rd_ptr;
    logic [FIFO_DEPTH_BITS:0]       fifo_count;
    logic                           fifo_empty, fifo_wr, fifo_rd;

    logic [FIFO_W-1:0]              head_word;
    logic [C_S_AXIS_DATA_WIDTH-1:0] head_data;
    logic [STRB_W-1:0]              head_strb;
    logic [C_S_AXIS_TUSER_WIDTH-1:0] head_user;
    logic                           head_last;

    logic [15:0]                    head_ethertype, head_csum;
    logic [3:0]                     head_version;
    logic [7:0]                     head_ttl;
    logic                           is_ipv4;
    logic [16:0]                    csum_sum;
    logic [15:0]                    csum_fold;

    logic [C_S_AXIS_DATA_WIDTH-1:0] out_data;
    logic [C_S_AXIS_TUSER_WIDTH-1:0] out_user;
    logic                           inc_ip, inc_expired, inc_non_ip;

    assign fifo_empty    = (fifo_count == '0);
    assign S_AXIS_TREADY = (fifo_count < NEARLY_FULL_LEVEL);
    assign fifo_wr       = S_AXIS_TVALID && S_AXIS_TREADY;
    assign fifo_rd       = !fifo_empty && (!M_AXIS_TVALID || M_AXIS_TREADY);

    assign head_word = fifo_mem[rd_ptr];
    assign {head_data, head_strb, head_user, head_last} = head_word;

    assign head_ethertype = head_data[159:144];
    assign head_version   = head_data[143:140];
    assign head_ttl       = head_data[79:72];
    assign head_csum      = head_data[63:48];
    assign is_ipv4        = (head_ethertype == 16'h0800) && (head_version == 4'h4);

    // RFC 1624: TTL drop of one changes the TTL/protocol word by -0x0100, i.e. adds 0xFEFF.
    assign csum_sum  = {1'b0, ~head_csum} + 17'h0_FEFF;
    assign csum_fold = csum_sum[15:0] + {15'd0, csum_sum[16]};

    always_ff @(posedge AXI_ACLK) begin
        if (fifo_wr)
            fifo_mem[wr_ptr] <= {S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TUSER, S_AXIS_TLAST};
    end

    always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
        if (AXI_RESET) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_wr)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (fifo_rd)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({fifo_wr, fifo_rd})
                2'b10:   fifo_count <= fifo_count + COUNT_ONE;
                2'b01:   fifo_count <= fifo_count - COUNT_ONE;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_comb begin
        out_data    = head_data;
        out_user    = head_user;
        inc_ip      = 1'b0;
        inc_expired = 1'b0;
        inc_non_ip  = 1'b0;
        next_state  = state;
        if (state == HEADER) begin
            if (!is_ipv4) begin
                inc_non_ip = 1'b1;
            end else if (head_ttl <= 8'd1) begin
                out_user[DST_PORT_POS +: 8] = {head_user[SRC_PORT_POS +: 7], 1'b0};
                inc_expired = 1'b1;
            end else begin
                out_data[79:72] = head_ttl - 8'd1;
                out_data[63:48] = ~csum_fold;
                inc_ip = 1'b1;
            end
        end
        if (fifo_rd) begin
            case (state)
                HEADER:  if (!head_last) next_state = BODY;
                BODY:    if (head_last)  next_state = HEADER;
                default: next_state = HEADER;
            endcase
        end
    end

    always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
        if (AXI_RESET)
            state <= HEADER;
        else
            state <= next_state;
    end

    always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
        if (AXI_RESET) begin
            M_AXIS_TDATA  <= '0;
            M_AXIS_TSTRB  <= '0;
            M_AXIS_TUSER  <= '0;
            M_AXIS_TLAST  <= 1'b0;
            M_AXIS_TVALID <= 1'b0;
        end else if (fifo_rd) begin
            M_AXIS_TDATA  <= out_data;
            M_AXIS_TSTRB  <= head_strb;
            M_AXIS_TUSER  <= out_user;
            M_AXIS_TLAST  <= head_last;
            M_AXIS_TVALID <= 1'b1;
        end else if (M_AXIS_TREADY) begin
            M_AXIS_TVALID <= 1'b0;
        end
    end

    // Events are counted when the first beat moves into the output register.
    always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
        if (AXI_RESET) begin
            ipv4_count        <= '0;
            ttl_expired_count <= '0;
            non_ip_count      <= '0;
        end else if (counter_reset) begin
            ipv4_count        <= '0;
            ttl_expired_count <= '0;
            non_ip_count      <= '0;
        end else if (fifo_rd) begin
            if (inc_ip)
                ipv4_count <= ipv4_count + 32'd1;
            if (inc_expired)
                ttl_expired_count <= ttl_expired_count + 32'd1;
            if (inc_non_ip)
                non_ip_count <= non_ip_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_ip_ttl_update.sv
// Scoreboard bench for ip_ttl_update: packets are modelled at byte level, expected beats
// are queued at issue time and a negedge monitor checks every output transfer.
module tb_ip_ttl_update;

    localparam int DW      = 256;
    localparam int UW      = 128;
    localparam int SW      = 32;
    localparam int SRC_POS = 16;
    localparam int DST_POS = 24;
    localparam int MAXB    = 32;

    logic           AXI_ACLK = 1'b0;
    logic           AXI_RESET;
    logic [DW-1:0]  S_AXIS_TDATA;
    logic [SW-1:0]  S_AXIS_TSTRB;
    logic [UW-1:0]  S_AXIS_TUSER;
    logic           S_AXIS_TVALID;
    logic           S_AXIS_TREADY;
    logic           S_AXIS_TLAST;
    logic [DW-1:0]  M_AXIS_TDATA;
    logic [SW-1:0]  M_AXIS_TSTRB;
    logic [UW-1:0]  M_AXIS_TUSER;
    logic           M_AXIS_TVALID;
    logic           M_AXIS_TREADY;
    logic           M_AXIS_TLAST;
    logic           counter_reset;
    logic [31:0]    ipv4_count, ttl_expired_count, non_ip_count;

    typedef struct {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    beat_t          sb[$];
    logic [DW-1:0]  in_data [MAXB];
    logic [SW-1:0]  in_strb [MAXB];
    logic [UW-1:0]  in_user [MAXB];
    beat_t          exp_beats [MAXB];
    int             pkt_len;

    int vectors = 0;
    int miscompares = 0;
    int m_ip = 0, m_exp = 0, m_non = 0;
    int ready_mode = 0;
    int beats_accepted = 0;

    ip_ttl_update #(
        .C_M_AXIS_DATA_WIDTH(DW), .C_S_AXIS_DATA_WIDTH(DW),
        .C_M_AXIS_TUSER_WIDTH(UW), .C_S_AXIS_TUSER_WIDTH(UW),
        .SRC_PORT_POS(SRC_POS), .DST_PORT_POS(DST_POS), .FIFO_DEPTH_BITS(4)
    ) dut (
        .AXI_ACLK(AXI_ACLK), .AXI_RESET(AXI_RESET),
        .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TSTRB(S_AXIS_TSTRB), .S_AXIS_TUSER(S_AXIS_TUSER),
        .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TREADY(S_AXIS_TREADY), .S_AXIS_TLAST(S_AXIS_TLAST),
        .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TSTRB(M_AXIS_TSTRB), .M_AXIS_TUSER(M_AXIS_TUSER),
        .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY), .M_AXIS_TLAST(M_AXIS_TLAST),
        .counter_reset(counter_reset), .ipv4_count(ipv4_count),
        .ttl_expired_count(ttl_expired_count), .non_ip_count(non_ip_count)
    );

    always #5 AXI_ACLK = ~AXI_ACLK;

    function automatic logic [7:0] get_byte(input logic [DW-1:0] w, input int i);
        return w[DW-1-8*i -: 8];
    endfunction

    function automatic logic [DW-1:0] set_byte(input logic [DW-1:0] w, input int i, input logic [7:0] v);
        logic [DW-1:0] r;
        r = w;
        r[DW-1-8*i -: 8] = v;
        return r;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge AXI_ACLK);
            #2;
        end
    endtask

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: works on the packet as bytes and applies the forwarding rules directly.
    task automatic modelPacket();
        logic [7:0]  b12, b13, b14, ttl, proto, c_hi, c_lo, src;
        logic [15:0] hc, m_old, m_new, n_hc, n_m;
        logic [8:0]  dbl;
        int unsigned s;
        for (int b = 0; b < pkt_len; b++)
            exp_beats[b] = '{in_data[b], in_strb[b], in_user[b], (b == pkt_len - 1)};
        b12   = get_byte(in_data[0], 12);
        b13   = get_byte(in_data[0], 13);
        b14   = get_byte(in_data[0], 14);
        ttl   = get_byte(in_data[0], 22);
        proto = get_byte(in_data[0], 23);
        c_hi  = get_byte(in_data[0], 24);
        c_lo  = get_byte(in_data[0], 25);
        if ({b12, b13} != 16'h0800 || b14[7:4] != 4'd4) begin
            m_non++;
        end else if (ttl < 8'd2) begin
            src = in_user[0][SRC_POS +: 8];
            dbl = {1'b0, src} * 9'd2;
            exp_beats[0].user[DST_POS +: 8] = dbl[7:0];
            m_exp++;
        end else begin
            hc    = {c_hi, c_lo};
            m_old = {ttl, proto};
            m_new = {ttl - 8'd1, proto};
            n_hc  = ~hc;
            n_m   = ~m_old;
            s = n_hc + n_m + m_new;
            while (s > 32'hFFFF)
                s = (s & 32'hFFFF) + (s >> 16);
            hc = ~s[15:0];
            exp_beats[0].data = set_byte(exp_beats[0].data, 22, ttl - 8'd1);
            exp_beats[0].data = set_byte(exp_beats[0].data, 24, hc[15:8]);
            exp_beats[0].data = set_byte(exp_beats[0].data, 25, hc[7:0]);
            m_ip++;
        end
    endtask

    task automatic buildPacket(input logic [15:0] etype, input logic [3:0] ver, input logic [7:0] ttl,
                               input logic [15:0] hc, input logic [7:0] src, input int len);
        pkt_len = len;
        for (int b = 0; b < len; b++) begin
            in_data[b] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            in_strb[b] = $urandom;
            in_user[b] = {$urandom, $urandom, $urandom, $urandom};
        end
        in_data[0] = set_byte(in_data[0], 12, etype[15:8]);
        in_data[0] = set_byte(in_data[0], 13, etype[7:0]);
        in_data[0] = set_byte(in_data[0], 14, {ver, 4'h5});
        in_data[0] = set_byte(in_data[0], 22, ttl);
        in_data[0] = set_byte(in_data[0], 24, hc[15:8]);
        in_data[0] = set_byte(in_data[0], 25, hc[7:0]);
        in_user[0][SRC_POS +: 8] = src;
        modelPacket();
    endtask

    task automatic applyStimulus(input int nsend);
        int  guard;
        bit  done;
        for (int b = 0; b < nsend; b++) begin
            S_AXIS_TDATA  = in_data[b];
            S_AXIS_TSTRB  = in_strb[b];
            S_AXIS_TUSER  = in_user[b];
            S_AXIS_TLAST  = (b == pkt_len - 1);
            S_AXIS_TVALID = 1'b1;
            guard = 0;
            done  = 1'b0;
            while (!done) begin
                @(negedge AXI_ACLK);
                if (S_AXIS_TREADY) begin
                    sb.push_back(exp_beats[b]);
                    beats_accepted++;
                    done = 1'b1;
                end else if (++guard > 2000) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL s_accept: beat %0d not accepted, got tready=0 expected 1", b);
                    S_AXIS_TVALID = 1'b0;
                    return;
                end
                @(posedge AXI_ACLK);
                #2;
            end
        end
        S_AXIS_TVALID = 1'b0;
    endtask

    task automatic checkOutput();
        beat_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL out_beat: got unexpected beat data=%h expected none", M_AXIS_TDATA);
        end else begin
            e = sb.pop_front();
            if (M_AXIS_TDATA !== e.data || M_AXIS_TUSER !== e.user ||
                M_AXIS_TSTRB !== e.strb || M_AXIS_TLAST !== e.last) begin
                miscompares++;
                $display("[TB] FAIL out_beat: got data=%h user=%h strb=%h last=%b expected data=%h user=%h strb=%h last=%b",
                         M_AXIS_TDATA, M_AXIS_TUSER, M_AXIS_TSTRB, M_AXIS_TLAST,
                         e.data, e.user, e.strb, e.last);
            end
        end
    endtask

    task automatic waitDrain();
        int g;
        g = 0;
        while ((sb.size() != 0 || M_AXIS_TVALID) && g < 3000) begin
            tick();
            g++;
        end
        vectors++;
        if (g >= 3000) begin
            miscompares++;
            $display("[TB] FAIL drain: got %0d beats outstanding expected 0", sb.size());
        end
    endtask

    task automatic checkCounters(input string tag);
        checkValue({tag, "_ipv4"}, ipv4_count, 32'(m_ip));
        checkValue({tag, "_expired"}, ttl_expired_count, 32'(m_exp));
        checkValue({tag, "_nonip"}, non_ip_count, 32'(m_non));
    endtask

    task automatic pulseCounterReset();
        counter_reset = 1'b1;
        tick();
        counter_reset = 1'b0;
        m_ip = 0;
        m_exp = 0;
        m_non = 0;
    endtask

    initial begin
        M_AXIS_TREADY = 1'b0;
        forever begin
            @(posedge AXI_ACLK);
            #2;
            case (ready_mode)
                0:       M_AXIS_TREADY = 1'b1;
                1:       M_AXIS_TREADY = ~M_AXIS_TREADY;
                2:       M_AXIS_TREADY = 1'($urandom_range(0, 1));
                default: M_AXIS_TREADY = 1'b0;
            endcase
        end
    end

    // Monitor: scoreboard pops, output hold-under-stall, and input FIFO occupancy vs ready.
    initial begin
        int acc, outc, occ;
        bit pend_in, pend_out, prev_stall;
        logic [417:0] snap_prev, snap_now;
        acc = 0; outc = 0; pend_in = 0; pend_out = 0; prev_stall = 0; snap_prev = '0;
        forever begin
            @(negedge AXI_ACLK);
            if (AXI_RESET) begin
                acc = 0; outc = 0; pend_in = 0; pend_out = 0; prev_stall = 0;
            end else begin
                acc  += int'(pend_in);
                outc += int'(pend_out);
                occ = acc - outc - int'(M_AXIS_TVALID);
                vectors++;
                if (S_AXIS_TREADY !== (occ < 15)) begin
                    miscompares++;
                    $display("[TB] FAIL s_tready: got %b expected %b (occupancy %0d)", S_AXIS_TREADY, (occ < 15), occ);
                end
                snap_now = {M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TSTRB, M_AXIS_TUSER, M_AXIS_TDATA};
                if (prev_stall) begin
                    vectors++;
                    if (snap_now !== snap_prev) begin
                        miscompares++;
                        $display("[TB] FAIL stall_hold: got %h expected %h", snap_now, snap_prev);
                    end
                end
                if (M_AXIS_TVALID && M_AXIS_TREADY)
                    checkOutput();
                prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
                snap_prev  = snap_now;
                pend_in    = S_AXIS_TVALID && S_AXIS_TREADY;
                pend_out   = M_AXIS_TVALID && M_AXIS_TREADY;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] et;
        logic [3:0]  ver;
        logic [7:0]  ttl;
        int          r;

        AXI_RESET     = 1'b1;
        S_AXIS_TDATA  = '0;
        S_AXIS_TSTRB  = '0;
        S_AXIS_TUSER  = '0;
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
        counter_reset = 1'b0;
        tick(3);
        checkValue("rst_tvalid", 32'(M_AXIS_TVALID), 32'd0);
        checkValue("rst_tdata", 32'(|M_AXIS_TDATA), 32'd0);
        checkValue("rst_tuser_tstrb_tlast", 32'(|{M_AXIS_TUSER, M_AXIS_TSTRB, M_AXIS_TLAST}), 32'd0);
        checkValue("rst_s_tready", 32'(S_AXIS_TREADY), 32'd1);
        checkCounters("rst");
        AXI_RESET = 1'b0;
        tick(2);

        $display("[TB] basic IPv4 decrement");
        ready_mode = 0;
        buildPacket(16'h0800, 4'd4, 8'h40, 16'hB861, 8'h04, 3);
        exp_beats[0].data = set_byte(exp_beats[0].data, 22, 8'h3F);
        exp_beats[0].data = set_byte(exp_beats[0].data, 24, 8'hB9);
        exp_beats[0].data = set_byte(exp_beats[0].data, 25, 8'h61);
        applyStimulus(3);
        waitDrain();
        checkValue("t1_ipv4_count", ipv4_count, 32'd1);

        $display("[TB] checksum 0xFEFF corner");
        buildPacket(16'h0800, 4'd4, 8'h10, 16'hFEFF, 8'h01, 2);
        exp_beats[0].data = set_byte(exp_beats[0].data, 22, 8'h0F);
        exp_beats[0].data = set_byte(exp_beats[0].data, 24, 8'h00);
        exp_beats[0].data = set_byte(exp_beats[0].data, 25, 8'h00);
        applyStimulus(2);
        waitDrain();

        $display("[TB] TTL expiry redirect");
        buildPacket(16'h0800, 4'd4, 8'h01, 16'(($urandom)), 8'h04, 2);
        exp_beats[0].user[DST_POS +: 8] = 8'h08;
        applyStimulus(2);
        waitDrain();
        checkValue("t3_expired_1", ttl_expired_count, 32'd1);
        buildPacket(16'h0800, 4'd4, 8'h00, 16'(($urandom)), 8'h04, 1);
        exp_beats[0].user[DST_POS +: 8] = 8'h08;
        applyStimulus(1);
        waitDrain();
        checkValue("t3_expired_2", ttl_expired_count, 32'd2);

        $display("[TB] single-beat ARP then IPv4");
        buildPacket(16'h0806, 4'd4, 8'h40, 16'h1234, 8'h02, 1);
        applyStimulus(1);
        buildPacket(16'h0800, 4'd4, 8'h22, 16'h4321, 8'h02, 2);
        applyStimulus(2);
        waitDrain();
        checkValue("t4_nonip", non_ip_count, 32'd1);
        checkCounters("t4");

        $display("[TB] backpressure fill and back-to-back packets");
        pulseCounterReset();
        ready_mode = 3;
        tick(2);
        beats_accepted = 0;
        buildPacket(16'h0800, 4'd4, 8'h30, 16'h0F0F, 8'h01, 20);
        fork
            applyStimulus(20);
        join_none
        tick(30);
        checkValue("fill_accepted", 32'(beats_accepted), 32'd16);
        checkValue("fill_s_tready", 32'(S_AXIS_TREADY), 32'd0);
        ready_mode = 1;
        wait fork;
        for (int p = 0; p < 20; p++) begin
            buildPacket(16'h0800, 4'd4, 8'(($urandom_range(2, 255))), 16'(($urandom)),
                        8'(1 << $urandom_range(0, 7)), $urandom_range(1, 4));
            applyStimulus(pkt_len);
        end
        waitDrain();
        checkValue("t5_ipv4_count", ipv4_count, 32'd21);
        checkCounters("t5");

        $display("[TB] randomized traffic");
        ready_mode = 2;
        for (int p = 0; p < 60; p++) begin
            r  = $urandom_range(0, 9);
            et = (r < 7) ? 16'h0800 : (r == 7) ? 16'h0806 : (r == 8) ? 16'h86DD : 16'(($urandom));
            ver = ($urandom_range(0, 7) == 0) ? 4'(($urandom)) : 4'd4;
            r  = $urandom_range(0, 5);
            ttl = (r == 0) ? 8'd0 : (r == 1) ? 8'd1 : (r == 2) ? 8'd2 : (r == 3) ? 8'hFF : 8'(($urandom));
            buildPacket(et, ver, ttl, 16'(($urandom)), 8'(1 << $urandom_range(0, 7)), $urandom_range(1, 4));
            applyStimulus(pkt_len);
            tick($urandom_range(0, 2));
        end
        ready_mode = 0;
        waitDrain();
        checkCounters("rand");

        $display("[TB] reset in the middle of a packet");
        ready_mode = 3;
        tick(2);
        buildPacket(16'h0800, 4'd4, 8'h20, 16'hAAAA, 8'h08, 3);
        applyStimulus(2);
        tick(2);
        checkValue("t6_tvalid_before", 32'(M_AXIS_TVALID), 32'd1);
        AXI_RESET = 1'b1;
        #1;
        sb.delete();
        checkValue("t6_tvalid_async", 32'(M_AXIS_TVALID), 32'd0);
        tick(2);
        m_ip = 0;
        m_exp = 0;
        m_non = 0;
        checkCounters("t6_rst");
        checkValue("t6_s_tready", 32'(S_AXIS_TREADY), 32'd1);
        ready_mode = 0;
        AXI_RESET = 1'b0;
        tick(2);
        buildPacket(16'h0800, 4'd4, 8'h05, 16'h1111, 8'h10, 1);
        applyStimulus(1);
        waitDrain();
        checkValue("t6_after_ipv4", ipv4_count, 32'd1);

        $display("[TB] counter clear against a same-cycle increment");
        buildPacket(16'h0800, 4'd4, 8'h09, 16'h2222, 8'h10, 1);
        applyStimulus(1);
        pulseCounterReset();
        waitDrain();
        checkValue("t6_clear_wins", ipv4_count, 32'd0);
        checkCounters("end");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
